divisor_8x8: RTL and testbench

DIVISOR_8X8 -- requirements
Module: divisor_8x8

---
 rtl/divisor_8x8_pkg.sv | 12 +
 rtl/divisor_8x8_subtrator.sv | 23 ++
 rtl/divisor_8x8.sv | 118 +++++++++++
 tb/tb_divisor_8x8.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/divisor_8x8_pkg.sv
// Shared ULA package: datapath width and divider FSM state encodings.
package divisor_8x8_pkg;

  localparam int ULA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_DONE   = 2'd2
  } div_state_e;

endpackage : divisor_8x8_pkg

// File: rtl/divisor_8x8_subtrator.sv
// Ripple-borrow subtractor: diff = a - b, bout = 1 when a < b (unsigned).
module subtrator_8x8 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  logic [WIDTH:0] bw;

  assign bw[0] = 1'b0;

  // One full-subtractor cell per bit; borrow ripples LSB to MSB.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign diff[i]  = a[i] ^ b[i] ^ bw[i];
    assign bw[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
  end

  assign bout = bw[WIDTH];

endmodule : subtrator_8x8

// File: rtl/divisor_8x8.sv
// Sequential restoring-style divider by repeated subtraction.
// One subtraction per cycle; latency is quotient+1 cycles after START.
module divisor_8x8
  import divisor_8x8_pkg::*;
#(
  parameter int WIDTH = ULA_WIDTH
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Quociente,
  output logic [WIDTH-1:0] Resto,
  output logic             DivZero,
  output logic             Pronto
);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             dz_q, dz_d;
  logic             pronto_q, pronto_d;

  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             rem_ge_b;
  logic [WIDTH-1:0] quo_inc;
  logic [WIDTH-1:0] carry;

  // The single subtractor serves both the compare and the update.
  subtrator_8x8 #(.WIDTH(WIDTH)) u_sub (
    .a    (rem_q),
    .b    (b_q),
    .diff (diff),
    .bout (bout)
  );

  assign rem_ge_b = ~bout;

  // Half-adder chain increments the quotient; it cannot wrap since Q <= 255.
  assign carry[0] = 1'b1;
  for (genvar i = 0; i < WIDTH; i++) begin : g_inc
    assign quo_inc[i] = quo_q[i] ^ carry[i];
    if (i < WIDTH - 1) begin : g_carry
      assign carry[i+1] = quo_q[i] & carry[i];
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    b_d      = b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dz_d     = dz_q;
    pronto_d = pronto_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          b_d   = B;
          rem_d = A;
          if (B == '0) begin
            quo_d    = '1;
            dz_d     = 1'b1;
            state_d  = ST_DONE;
            pronto_d = 1'b1;
          end else begin
            quo_d    = '0;
            dz_d     = 1'b0;
            state_d  = ST_DIVIDE;
            pronto_d = 1'b0;
          end
        end
      end
      ST_DIVIDE: begin
        // START is deliberately not looked at here.
        if (rem_ge_b) begin
          rem_d = diff;
          quo_d = quo_inc;
        end else begin
          state_d  = ST_DONE;
          pronto_d = 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        pronto_d = 1'b0;
      end
    endcase
  end

  // FSM state and all result registers; reset aborts any operation.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= ST_IDLE;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dz_q     <= 1'b0;
      pronto_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dz_q     <= dz_d;
      pronto_q <= pronto_d;
    end
  end

  assign Quociente = quo_q;
  assign Resto     = rem_q;
  assign DivZero   = dz_q;
  assign Pronto    = pronto_q;

endmodule : divisor_8x8

// File: tb/tb_divisor_8x8.sv
// Directed bench for divisor_8x8: vector table plus multi-cycle corner sequences.
module tb_divisor_8x8;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b0;
  logic       START = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic [7:0] Quociente, Resto;
  logic       DivZero, Pronto;

  int checks = 0;
  int failures = 0;

  divisor_8x8 dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .START     (START),
    .A         (A),
    .B         (B),
    .Quociente (Quociente),
    .Resto     (Resto),
    .DivZero   (DivZero),
    .Pronto    (Pronto)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         lat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulse START for one edge (edge k); returns #1 after edge k and scrambles A/B.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    @(negedge CLOCK);
    A = a; B = b; START = 1'b1;
    @(posedge CLOCK);
    #1;
    START = 1'b0;
    A = 8'($urandom);
    B = 8'($urandom);
  endtask

  // Count edges after the current one until Pronto rises (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!Pronto && lat < 300) begin
      @(posedge CLOCK);
      #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input vec_t v, input int lat);
    chk({tag, " latency"}, lat, v.lat);
    chk({tag, " pronto"}, int'(Pronto), 1);
    chk({tag, " quociente"}, int'(Quociente), int'(v.q));
    chk({tag, " resto"}, int'(Resto), int'(v.r));
    chk({tag, " divzero"}, int'(DivZero), int'(v.dz));
  endtask

  vec_t vecs[10];
  vec_t v;
  int   lat;

  initial begin
    vecs[0] = '{a: 8'd200, b: 8'd7,   q: 8'd28,  r: 8'd4,  dz: 1'b0, lat: 29};
    vecs[1] = '{a: 8'd5,   b: 8'd0,   q: 8'hFF,  r: 8'd5,  dz: 1'b1, lat: 0};
    vecs[2] = '{a: 8'd3,   b: 8'd9,   q: 8'd0,   r: 8'd3,  dz: 1'b0, lat: 1};
    vecs[3] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,  dz: 1'b0, lat: 256};
    vecs[4] = '{a: 8'd0,   b: 8'd5,   q: 8'd0,   r: 8'd0,  dz: 1'b0, lat: 1};
    vecs[5] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,  dz: 1'b0, lat: 2};
    vecs[6] = '{a: 8'd17,  b: 8'd4,   q: 8'd4,   r: 8'd1,  dz: 1'b0, lat: 5};
    vecs[7] = '{a: 8'd0,   b: 8'd0,   q: 8'hFF,  r: 8'd0,  dz: 1'b1, lat: 0};
    vecs[8] = '{a: 8'd128, b: 8'd3,   q: 8'd42,  r: 8'd2,  dz: 1'b0, lat: 43};
    vecs[9] = '{a: 8'd255, b: 8'd16,  q: 8'd15,  r: 8'd15, dz: 1'b0, lat: 16};

    // Reset state
    #12;
    chk("reset quociente", int'(Quociente), 0);
    chk("reset resto", int'(Resto), 0);
    chk("reset divzero", int'(DivZero), 0);
    chk("reset pronto", int'(Pronto), 0);
    @(negedge CLOCK);
    RESET = 1'b1;

    // Vector table; each op after the first restarts from DONE
    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      start_op(v.a, v.b);
      wait_done(lat);
      check_result($sformatf("vec%0d", i), v, lat);
      // Results hold in DONE while inputs wander
      repeat (3) @(posedge CLOCK);
      #1;
      chk($sformatf("vec%0d hold q", i), int'(Quociente), int'(v.q));
      chk($sformatf("vec%0d hold r", i), int'(Resto), int'(v.r));
      chk($sformatf("vec%0d hold pronto", i), int'(Pronto), 1);
    end

    // START during DIVIDE is ignored
    start_op(8'd100, 8'd10);
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    A = 8'd9; B = 8'd3; START = 1'b1;
    @(posedge CLOCK);
    #1;
    START = 1'b0;
    A = 8'd77; B = 8'd1;
    chk("ignore pronto low", int'(Pronto), 0);
    wait_done(lat);
    v = '{a: 8'd100, b: 8'd10, q: 8'd10, r: 8'd0, dz: 1'b0, lat: 8};
    check_result("ignore", v, lat);

    // Back-to-back restart: Pronto falls at the START edge
    start_op(8'd17, 8'd4);
    chk("b2b pronto fall", int'(Pronto), 0);
    wait_done(lat);
    v = '{a: 8'd17, b: 8'd4, q: 8'd4, r: 8'd1, dz: 1'b0, lat: 5};
    check_result("b2b", v, lat);

    // Asynchronous reset mid-operation
    start_op(8'd100, 8'd10);
    repeat (4) @(posedge CLOCK);
    #2;
    RESET = 1'b0;
    #1;
    chk("midrst quociente", int'(Quociente), 0);
    chk("midrst resto", int'(Resto), 0);
    chk("midrst divzero", int'(DivZero), 0);
    chk("midrst pronto", int'(Pronto), 0);
    repeat (2) @(posedge CLOCK);
    #1;
    chk("midrst held pronto", int'(Pronto), 0);
    @(negedge CLOCK);
    RESET = 1'b1;
    start_op(8'd50, 8'd5);
    wait_done(lat);
    v = '{a: 8'd50, b: 8'd5, q: 8'd10, r: 8'd0, dz: 1'b0, lat: 11};
    check_result("postrst", v, lat);

    // Divide-by-zero restart from DONE keeps Pronto high
    start_op(8'd9, 8'd0);
    chk("dz restart pronto", int'(Pronto), 1);
    chk("dz restart quociente", int'(Quociente), 255);
    chk("dz restart resto", int'(Resto), 9);
    chk("dz restart divzero", int'(DivZero), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_divisor_8x8
